// File: rtl/tx_xgmii_arb.sv
// Two-port transmit scheduler in front of tx_xgmii: arbitrates port A (data) and
// port B (control), then streams the granted frame as rts + back-to-back words and a gap.
module tx_xgmii_arb #(
    parameter int unsigned GAP_STEPS = 2,
    parameter int unsigned PRIO_B    = 1,
    parameter int unsigned MAX_B_RUN = 4
) (
    input  logic        clk156,
    input  logic        rst,
    input  logic        step,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] bytes_a,
    input  logic [15:0] bytes_b,
    input  logic [63:0] data_a,
    input  logic [63:0] data_b,
    output logic        rd_a,
    output logic        rd_b,
    output logic        rts,
    output logic [63:0] rdata,
    output logic [15:0] rbytes,
    output logic        busy,
    output logic        sel,
    output logic        err,
    output logic [15:0] pkt_cnt_a,
    output logic [15:0] pkt_cnt_b
);
    localparam int unsigned WCNT_W = 16;
    localparam int unsigned GCNT_W = 4;
    localparam int unsigned BRUN_W = 8;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_SEND = 3'b010;
    localparam logic [2:0] S_GAP  = 3'b100;

    localparam logic [GCNT_W-1:0] GAP_INIT = GCNT_W'(GAP_STEPS);
    localparam logic [BRUN_W-1:0] BRUN_MAX = BRUN_W'(MAX_B_RUN);

    logic [2:0]        state_q, state_d;
    logic              rts_q, rts_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [15:0]       rbytes_q, rbytes_d;
    logic              sel_q, sel_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_a_q, cnt_a_d;
    logic [15:0]       cnt_b_q, cnt_b_d;
    logic [BRUN_W-1:0] b_run_q, b_run_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    logic              any_req;
    logic              win_b;
    logic              port;
    logic              pop;
    logic [15:0]       g_bytes;
    logic [63:0]       g_data;
    logic [WCNT_W-1:0] words;

    // Arbitration winner and the currently addressed port's descriptor/word
    always_comb begin
        any_req = req_a | req_b;
        if (req_a && req_b) begin
            win_b = (PRIO_B != 0) ? (b_run_q != BRUN_MAX) : ~sel_q;
        end else begin
            win_b = req_b;
        end
        port    = (state_q == S_IDLE) ? win_b : sel_q;
        g_bytes = port ? bytes_b : bytes_a;
        g_data  = port ? data_b : data_a;
        words   = {3'b000, g_bytes[15:3]} + WCNT_W'(|g_bytes[2:0]);
    end

    // Next-state and registered-output logic; everything advances only on step
    always_comb begin
        state_d  = state_q;
        rts_d    = rts_q;
        rdata_d  = rdata_q;
        rbytes_d = rbytes_q;
        sel_d    = sel_q;
        err_d    = 1'b0;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        b_run_d  = b_run_q;
        wcnt_d   = wcnt_q;
        gcnt_d   = gcnt_q;
        pop      = 1'b0;
        if (step) begin
            case (state_q)
                S_IDLE: begin
                    rts_d = 1'b0;
                    if (!req_a) begin
                        b_run_d = '0;
                    end
                    if (any_req) begin
                        pop   = 1'b1;
                        sel_d = win_b;
                        if (!win_b) begin
                            b_run_d = '0;
                        end else if (req_a && (b_run_q != BRUN_MAX)) begin
                            b_run_d = b_run_q + BRUN_W'(1);
                        end
                        if (g_bytes == 16'd0) begin
                            err_d = 1'b1;
                        end else begin
                            rts_d    = 1'b1;
                            rdata_d  = g_data;
                            rbytes_d = g_bytes;
                            if (win_b) begin
                                cnt_b_d = cnt_b_q + 16'd1;
                            end else begin
                                cnt_a_d = cnt_a_q + 16'd1;
                            end
                            wcnt_d = words - WCNT_W'(1);
                            if (words > WCNT_W'(1)) begin
                                state_d = S_SEND;
                            end else begin
                                state_d = S_GAP;
                                gcnt_d  = GAP_INIT;
                            end
                        end
                    end
                end
                S_SEND: begin
                    rts_d   = 1'b0;
                    rdata_d = g_data;
                    pop     = 1'b1;
                    wcnt_d  = wcnt_q - WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_d = S_GAP;
                        gcnt_d  = GAP_INIT;
                    end
                end
                S_GAP: begin
                    rts_d  = 1'b0;
                    gcnt_d = gcnt_q - GCNT_W'(1);
                    if (gcnt_q == GCNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rts_q    <= 1'b0;
            rdata_q  <= '0;
            rbytes_q <= '0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            b_run_q  <= '0;
            wcnt_q   <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            rts_q    <= rts_d;
            rdata_q  <= rdata_d;
            rbytes_q <= rbytes_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            b_run_q  <= b_run_d;
            wcnt_q   <= wcnt_d;
            gcnt_q   <= gcnt_d;
        end
    end

    // FIFO pops are combinational so the FIFO advances on the capturing edge
    assign rd_a      = pop & ~port & ~rst;
    assign rd_b      = pop & port & ~rst;
    assign rts       = rts_q;
    assign rdata     = rdata_q;
    assign rbytes    = rbytes_q;
    assign busy      = (state_q != S_IDLE);
    assign sel       = sel_q;
    assign err       = err_q;
    assign pkt_cnt_a = cnt_a_q;
    assign pkt_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_tx_xgmii_arb.sv
// Bench for tx_xgmii_arb: queue-based requester model plus a frame-slot reference model.
module tb_tx_xgmii_arb;
    localparam int unsigned GAP  = 2;
    localparam int unsigned MAXB = 4;
    localparam int          OW   = 116;

    logic        clk = 1'b0;
    logic        rst, rst_rr, step, req_a, req_b;
    logic [15:0] bytes_a, bytes_b;
    logic [63:0] data_a, data_b;
    logic        rd_a, rd_b, rts, sel, err, busy;
    logic [63:0] rdata;
    logic [15:0] rbytes, pkt_cnt_a, pkt_cnt_b;
    logic        rr_rd_a, rr_rd_b, rr_rts, rr_sel, rr_err, rr_busy;
    logic [63:0] rr_rdata;
    logic [15:0] rr_rbytes, rr_cnt_a, rr_cnt_b;

    always #5 clk = ~clk;

    tx_xgmii_arb #(.GAP_STEPS(GAP), .PRIO_B(1), .MAX_B_RUN(MAXB)) u_dut (
        .clk156(clk), .rst(rst), .step(step), .req_a(req_a), .req_b(req_b),
        .bytes_a(bytes_a), .bytes_b(bytes_b), .data_a(data_a), .data_b(data_b),
        .rd_a(rd_a), .rd_b(rd_b), .rts(rts), .rdata(rdata), .rbytes(rbytes),
        .busy(busy), .sel(sel), .err(err), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
    );

    tx_xgmii_arb #(.GAP_STEPS(GAP), .PRIO_B(0), .MAX_B_RUN(MAXB)) u_rr (
        .clk156(clk), .rst(rst_rr), .step(step), .req_a(1'b1), .req_b(1'b1),
        .bytes_a(16'd8), .bytes_b(16'd5), .data_a(64'h0123_4567_89ab_cdef),
        .data_b(64'hfedc_ba98_7654_3210),
        .rd_a(rr_rd_a), .rd_b(rr_rd_b), .rts(rr_rts), .rdata(rr_rdata), .rbytes(rr_rbytes),
        .busy(rr_busy), .sel(rr_sel), .err(rr_err), .pkt_cnt_a(rr_cnt_a), .pkt_cnt_b(rr_cnt_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Requester side: store-and-forward frame queues with a show-ahead word index
    logic [15:0] qa_bytes[$], qb_bytes[$];
    logic [63:0] qa_base[$], qb_base[$];
    int          wa, wb;

    // Reference model of what the scheduler should present
    logic        m_rts, m_sel, m_err, m_active;
    logic [63:0] m_rdata;
    logic [15:0] m_rbytes, m_cnt_a, m_cnt_b;
    int          m_brun, m_t, m_n;

    function automatic int nwords(input logic [15:0] b);
        return int'(b) / 8 + (((int'(b) % 8) != 0) ? 1 : 0);
    endfunction

    function automatic logic [15:0] head_bytes(input logic p);
        if (p) return (qb_bytes.size() != 0) ? qb_bytes[0] : 16'h0;
        return (qa_bytes.size() != 0) ? qa_bytes[0] : 16'h0;
    endfunction

    function automatic logic [63:0] head_data(input logic p);
        if (p) return (qb_base.size() != 0) ? qb_base[0] + 64'(wb) : 64'h0;
        return (qa_base.size() != 0) ? qa_base[0] + 64'(wa) : 64'h0;
    endfunction

    task automatic push(input logic p, input logic [15:0] b);
        logic [63:0] base;
        base = {$urandom, $urandom};
        if (p) begin qb_bytes.push_back(b); qb_base.push_back(base); end
        else   begin qa_bytes.push_back(b); qa_base.push_back(base); end
    endtask

    task automatic drop_head(input logic p);
        if (p && qb_bytes.size() != 0) begin
            void'(qb_bytes.pop_front()); void'(qb_base.pop_front()); wb = 0;
        end else if (!p && qa_bytes.size() != 0) begin
            void'(qa_bytes.pop_front()); void'(qa_base.pop_front()); wa = 0;
        end
    endtask

    task automatic pop_word(input logic p);
        if (p) begin
            wb++;
            if (wb >= nwords(head_bytes(1'b1))) drop_head(1'b1);
        end else begin
            wa++;
            if (wa >= nwords(head_bytes(1'b0))) drop_head(1'b0);
        end
    endtask

    // One clock: drive inputs, predict, sample pops before the edge and outputs after it
    task automatic cycle(input logic st, input logic rs,
                         output logic [1:0] g_rd, output logic [1:0] e_rd,
                         output logic [OW-1:0] g_o, output logic [OW-1:0] e_o);
        logic ra, rb, gb;
        logic [15:0] by;
        @(negedge clk);
        ra = (qa_bytes.size() != 0);
        rb = (qb_bytes.size() != 0);
        rst = rs; step = st; req_a = ra; req_b = rb;
        bytes_a = head_bytes(1'b0); bytes_b = head_bytes(1'b1);
        data_a  = head_data(1'b0);  data_b  = head_data(1'b1);
        e_rd  = 2'b00;
        m_err = 1'b0;
        if (rs) begin
            m_rts = 1'b0; m_rdata = '0; m_rbytes = '0; m_sel = 1'b0;
            m_cnt_a = '0; m_cnt_b = '0; m_brun = 0; m_active = 1'b0; m_t = 0; m_n = 0;
            if (wa != 0) drop_head(1'b0);
            if (wb != 0) drop_head(1'b1);
        end else if (st) begin
            if (!m_active) begin
                m_rts = 1'b0;
                if (!ra) m_brun = 0;
                if (ra || rb) begin
                    gb = (ra && rb) ? (m_brun < int'(MAXB)) : rb;
                    if (!gb) m_brun = 0;
                    else if (ra) m_brun = m_brun + 1;
                    m_sel = gb;
                    e_rd  = gb ? 2'b01 : 2'b10;
                    by    = head_bytes(gb);
                    if (by == 16'd0) begin
                        m_err = 1'b1;
                    end else begin
                        m_rts = 1'b1; m_rdata = head_data(gb); m_rbytes = by;
                        if (gb) m_cnt_b = m_cnt_b + 16'd1; else m_cnt_a = m_cnt_a + 16'd1;
                        m_active = 1'b1; m_t = 0; m_n = nwords(by);
                    end
                    pop_word(gb);
                end
            end else begin
                m_rts = 1'b0;
                m_t   = m_t + 1;
                if (m_t < m_n) begin
                    m_rdata = head_data(m_sel);
                    e_rd    = m_sel ? 2'b01 : 2'b10;
                    pop_word(m_sel);
                end
                if (m_t >= m_n + int'(GAP) - 1) m_active = 1'b0;
            end
        end
        #1;
        g_rd = {rd_a, rd_b};
        @(posedge clk);
        #1;
        g_o = {rts, rdata, rbytes, sel, err, busy, pkt_cnt_a, pkt_cnt_b};
        e_o = {m_rts, m_rdata, m_rbytes, m_sel, m_err, m_active, m_cnt_a, m_cnt_b};
    endtask

    task automatic do_reset();
        logic [1:0] a, b;
        logic [OW-1:0] c, d;
        qa_bytes.delete(); qa_base.delete(); qb_bytes.delete(); qb_base.delete();
        wa = 0; wb = 0;
        cycle(1'b1, 1'b1, a, b, c, d);
        cycle(1'b1, 1'b1, a, b, c, d);
    endtask

    task automatic test_reset();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        do_reset();
        push(1'b0, 16'd64);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, gr, er, go, eo);
            n_chk++; if (gr !== 2'b00) $display("FAIL reset_rd got %b exp 00", gr); else n_pass++;
            n_chk++; if (go !== '0) $display("FAIL reset_out got %h exp 0", go); else n_pass++;
        end
    endtask

    task automatic test_single_a();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        int rts_hi, rda_hi, idle_at;
        do_reset();
        push(1'b0, 16'd64);
        rts_hi = 0; rda_hi = 0; idle_at = -1;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, gr, er, go, eo);
            n_chk++; if (gr !== er) $display("FAIL single_rd cyc %0d got %b exp %b", i, gr, er); else n_pass++;
            n_chk++; if (go !== eo) $display("FAIL single_out cyc %0d got %h exp %h", i, go, eo); else n_pass++;
            if (rts) rts_hi++;
            if (gr[1]) rda_hi++;
            if (!busy && idle_at < 0 && i > 0) idle_at = i;
        end
        n_chk++; if (rts_hi !== 1) $display("FAIL single_rts_width got %0d exp 1", rts_hi); else n_pass++;
        n_chk++; if (rda_hi !== 8) $display("FAIL single_rd_count got %0d exp 8", rda_hi); else n_pass++;
        n_chk++; if (pkt_cnt_a !== 16'd1) $display("FAIL single_cnt got %0d exp 1", pkt_cnt_a); else n_pass++;
        n_chk++; if (idle_at !== 9) $display("FAIL single_busy_fall got %0d exp 9", idle_at); else n_pass++;
    endtask

    task automatic test_prio_b();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        logic [9:0] order, exp_order;
        int ng;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            push(1'b0, 16'($urandom_range(1, 8)));
            push(1'b1, 16'($urandom_range(1, 8)));
        end
        order = '0; ng = 0; exp_order = 10'b1111011110;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0, gr, er, go, eo);
            n_chk++; if (gr !== er) $display("FAIL prio_rd cyc %0d got %b exp %b", i, gr, er); else n_pass++;
            n_chk++; if (go !== eo) $display("FAIL prio_out cyc %0d got %h exp %h", i, go, eo); else n_pass++;
            if (rts) begin order = {order[8:0], sel}; ng++; end
        end
        n_chk++; if (ng !== 10) $display("FAIL prio_grants got %0d exp 10", ng); else n_pass++;
        n_chk++; if (order !== exp_order) $display("FAIL prio_order got %b exp %b", order, exp_order); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        logic exp_sel;
        int ng;
        do_reset();
        rst_rr = 1'b0;
        exp_sel = 1'b1; ng = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0, gr, er, go, eo);
            if (rr_rts) begin
                n_chk++; if (rr_sel !== exp_sel) $display("FAIL rr_sel grant %0d got %b exp %b", ng, rr_sel, exp_sel); else n_pass++;
                exp_sel = ~exp_sel; ng++;
            end
        end
        n_chk++; if (ng !== 10) $display("FAIL rr_grants got %0d exp 10", ng); else n_pass++;
        n_chk++; if (rr_cnt_a !== 16'd5) $display("FAIL rr_cnt_a got %0d exp 5", rr_cnt_a); else n_pass++;
        n_chk++; if (rr_cnt_b !== 16'd5) $display("FAIL rr_cnt_b got %0d exp 5", rr_cnt_b); else n_pass++;
        rst_rr = 1'b1;
    endtask

    task automatic test_zero_len();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        do_reset();
        push(1'b1, 16'd0);
        push(1'b0, 16'd64);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, gr, er, go, eo);
            n_chk++; if (gr !== er) $display("FAIL zero_rd cyc %0d got %b exp %b", i, gr, er); else n_pass++;
            n_chk++; if (go !== eo) $display("FAIL zero_out cyc %0d got %h exp %h", i, go, eo); else n_pass++;
            if (i == 0) begin
                n_chk++; if (gr !== 2'b01) $display("FAIL zero_pop got %b exp 01", gr); else n_pass++;
                n_chk++; if ({err, rts} !== 2'b10) $display("FAIL zero_err got err=%b rts=%b exp err=1 rts=0", err, rts); else n_pass++;
                n_chk++; if (pkt_cnt_b !== 16'd0) $display("FAIL zero_cnt_b got %0d exp 0", pkt_cnt_b); else n_pass++;
            end
            if (i == 1) begin
                n_chk++; if ({rts, sel, err} !== 3'b100) $display("FAIL zero_next_grant got rts=%b sel=%b err=%b exp 1 0 0", rts, sel, err); else n_pass++;
            end
        end
    endtask

    task automatic test_slow_step();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        int rts_hi;
        do_reset();
        push(1'b0, 16'd13);
        push(1'b0, 16'd13);
        rts_hi = 0;
        for (int i = 0; i < 40; i++) begin
            cycle((i % 4) == 3, 1'b0, gr, er, go, eo);
            n_chk++; if (gr !== er) $display("FAIL slow_rd cyc %0d got %b exp %b", i, gr, er); else n_pass++;
            n_chk++; if (go !== eo) $display("FAIL slow_out cyc %0d got %h exp %h", i, go, eo); else n_pass++;
            if (rts) rts_hi++;
        end
        n_chk++; if (rts_hi !== 8) $display("FAIL slow_rts_clocks got %0d exp 8", rts_hi); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        do_reset();
        push(1'b0, 16'd60);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, gr, er, go, eo);
            n_chk++; if (go !== eo) $display("FAIL midrst_pre cyc %0d got %h exp %h", i, go, eo); else n_pass++;
        end
        cycle(1'b1, 1'b1, gr, er, go, eo);
        n_chk++; if (gr !== 2'b00) $display("FAIL midrst_rd got %b exp 00", gr); else n_pass++;
        n_chk++; if ({rts, busy, rdata, pkt_cnt_a} !== '0) $display("FAIL midrst_clear got rts=%b busy=%b rdata=%h cnt=%0d exp all 0", rts, busy, rdata, pkt_cnt_a); else n_pass++;
        push(1'b0, 16'd16);
        cycle(1'b1, 1'b0, gr, er, go, eo);
        n_chk++; if (go !== eo) $display("FAIL midrst_regrant got %h exp %h", go, eo); else n_pass++;
        n_chk++; if ({rts, rbytes} !== {1'b1, 16'd16}) $display("FAIL midrst_rts got rts=%b rbytes=%0d exp 1 16", rts, rbytes); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [1:0] gr, er;
        logic [OW-1:0] go, eo;
        logic [15:0] b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0 && ((p == 0) ? qa_bytes.size() : qb_bytes.size()) < 3) begin
                    b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 72));
                    push(p[0], b);
                end
            end
            cycle($urandom_range(0, 3) != 0, i == 300, gr, er, go, eo);
            n_chk++; if (gr !== er) $display("FAIL rand_rd cyc %0d got %b exp %b", i, gr, er); else n_pass++;
            n_chk++; if (go !== eo) $display("FAIL rand_out cyc %0d got %h exp %h", i, go, eo); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; rst_rr = 1'b1; step = 1'b0; req_a = 1'b0; req_b = 1'b0;
        bytes_a = '0; bytes_b = '0; data_a = '0; data_b = '0;
        wa = 0; wb = 0;
        test_reset();
        test_single_a();
        test_prio_b();
        test_round_robin();
        test_zero_len();
        test_slow_step();
        test_reset_mid_frame();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
